// File: rtl/ysyx_23060124_pkg.sv
// Shared definitions for the write-back unit: FSM state encoding and load-size codes.
package ysyx_23060124_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_COMMIT    = 2'd2
    } wbu_state_e;

    localparam logic [1:0] LS_BYTE = 2'd0;
    localparam logic [1:0] LS_HALF = 2'd1;
    localparam logic [1:0] LS_WORD = 2'd2;

endpackage

// File: rtl/ysyx_23060124_load_ext.sv
// Combinational load-data extraction: selects byte/half/word lanes from an aligned word
// and sign- or zero-extends the result.
module ysyx_23060124_load_ext
    import ysyx_23060124_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'h00;
        case (addr_i)
            2'd0:    byte_v = rdata_i[7:0];
            2'd1:    byte_v = rdata_i[15:8];
            2'd2:    byte_v = rdata_i[23:16];
            default: byte_v = rdata_i[31:24];
        endcase
        half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        // Size code 3 is not a legal load width; it falls through to a full word.
        case (size_i)
            LS_BYTE: data_o = {{24{sign_i & byte_v[7]}}, byte_v};
            LS_HALF: data_o = {{16{sign_i & half_v[15]}}, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/ysyx_23060124_wbu.sv
// Write-back unit: accepts EXU results, waits for load data, and writes the register file.
// Optional commit trace ports are enabled by defining YSYX_23060124_COMMIT_TRACE_EN.
module ysyx_23060124_wbu
    import ysyx_23060124_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_rd,
    input  logic        in_wen,
    input  logic        in_is_load,
    input  logic [31:0] in_alu_res,
    input  logic [1:0]  in_load_size,
    input  logic        in_load_sign,
    input  logic [31:0] in_pc,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rf_wen,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [3:0]  wbu_rd
`ifdef YSYX_23060124_COMMIT_TRACE_EN
    ,
    output logic        commit_valid,
    output logic [31:0] commit_pc
`endif
);

    wbu_state_e  state_q, state_d;
    logic [3:0]  rd_q;
    logic        wen_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [1:0]  addr_q;
    logic [31:0] result_q;
    logic [31:0] load_val;
    logic        transfer;

    assign transfer = in_valid && in_ready;

    ysyx_23060124_load_ext u_load_ext (
        .rdata_i (mem_rdata),
        .addr_i  (addr_q),
        .size_i  (size_q),
        .sign_i  (sign_q),
        .data_o  (load_val)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD_WAIT: if (mem_rvalid) state_d = ST_COMMIT;
            ST_COMMIT:    state_d = in_valid ? (in_is_load ? ST_LOAD_WAIT : ST_COMMIT) : ST_IDLE;
            default:      if (in_valid) state_d = in_is_load ? ST_LOAD_WAIT : ST_COMMIT;
        endcase
    end

    always_comb begin
        in_ready = (state_q != ST_LOAD_WAIT);
        rf_wen   = (state_q == ST_COMMIT) && wen_q && (rd_q != 4'd0);
        rf_waddr = rd_q;
        rf_wdata = result_q;
        wbu_rd   = ((state_q != ST_IDLE) && wen_q) ? rd_q : 4'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q     <= 4'd0;
            wen_q    <= 1'b0;
            size_q   <= 2'd0;
            sign_q   <= 1'b0;
            addr_q   <= 2'd0;
            result_q <= 32'd0;
        end else if (transfer) begin
            rd_q     <= in_rd;
            wen_q    <= in_wen;
            size_q   <= in_load_size;
            sign_q   <= in_load_sign;
            addr_q   <= in_alu_res[1:0];
            result_q <= in_alu_res;
        end else if ((state_q == ST_LOAD_WAIT) && mem_rvalid) begin
            result_q <= load_val;
        end
    end

`ifdef YSYX_23060124_COMMIT_TRACE_EN
    logic [31:0] pc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= 32'd0;
        end else if (transfer) begin
            pc_q <= in_pc;
        end
    end

    assign commit_valid = (state_q == ST_COMMIT);
    assign commit_pc    = pc_q;
`else
    logic unused_pc;
    assign unused_pc = ^in_pc;
`endif

endmodule

// File: doc/ysyx_23060124_wbu.md
YSYX_23060124_WBU -- requirements
Module: ysyx_23060124_wbu

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have upstream ports: in_valid in 1 (EXU result valid); in_ready out 1 (WBU accepts); in_rd in 4 (destination reg); in_wen in 1 (instruction writes rd); in_is_load in 1; in_alu_res in 32 (ALU result / load address); in_load_size in 2 (0 byte, 1 half, 2 word); in_load_sign in 1 (1 = sign-extend); in_pc in 32.
REQ-004 SHALL have memory ports: mem_rvalid in 1 (load data valid, one-cycle pulse); mem_rdata in 32 (aligned word containing the load data).
REQ-005 SHALL have register-file write ports: rf_wen out 1; rf_waddr out 4; rf_wdata out 32.
REQ-006 SHALL have hazard port: wbu_rd out 4 (rd of the instruction held in WBU; 0 when none or when in_wen=0).
REQ-007 SHALL have trace ports, present only with the macro in REQ-024: commit_valid out 1; commit_pc out 32.

Function
REQ-008 SHALL implement states IDLE, LOAD_WAIT, COMMIT.
REQ-009 Handshake: a transfer SHALL occur on a cycle where in_valid && in_ready; in_ready SHALL be 1 in IDLE and COMMIT and 0 in LOAD_WAIT.
REQ-010 Transfer with in_is_load=0 SHALL move to COMMIT and latch rd, wen, in_alu_res as the result, and pc.
REQ-011 Transfer with in_is_load=1 SHALL move to LOAD_WAIT and latch rd, wen, size, sign, in_alu_res[1:0], and pc.
REQ-012 In LOAD_WAIT, mem_rvalid=1 SHALL move to COMMIT with the extracted load value latched; otherwise the block SHALL remain in LOAD_WAIT indefinitely.
REQ-013 Load extraction: byte = mem_rdata[8*addr[1:0] +: 8]; half = mem_rdata[16*addr[1] +: 16]; word = mem_rdata; sign- or zero-extend per in_load_sign; size 3 SHALL be treated as word.
REQ-014 In COMMIT, rf_wen SHALL be 1 for exactly that cycle iff latched wen=1 and rd!=0; rf_waddr/rf_wdata SHALL carry latched rd/result.
REQ-015 In COMMIT with a simultaneous transfer, the next state SHALL follow REQ-010/011 (back-to-back); without one, the next state SHALL be IDLE.
REQ-016 Latency: an ALU instruction accepted at cycle N SHALL write at N+1; a load whose mem_rvalid arrives at cycle M SHALL write at M+1.
REQ-017 rf_wen SHALL be 0 in IDLE and LOAD_WAIT; rf_waddr/rf_wdata are don't-care when rf_wen=0.
REQ-018 wbu_rd SHALL equal latched rd in LOAD_WAIT and COMMIT when latched wen=1, else 0.
REQ-019 mem_rvalid in IDLE or COMMIT SHALL be ignored with no state change.

Reset
REQ-020 reset SHALL force IDLE, in_ready=1, rf_wen=0, wbu_rd=0, commit_valid=0, and clear all latched fields to 0.
REQ-021 reset during LOAD_WAIT SHALL abandon the load with no register write; a later mem_rvalid SHALL be ignored per REQ-019.
REQ-022 reset SHALL take priority over a simultaneous transfer or mem_rvalid.

Configuration
REQ-023 Macro YSYX_23060124_COMMIT_TRACE_EN SHALL control the trace feature.
REQ-024 With the macro defined, commit_valid SHALL be 1 for each COMMIT cycle, including cycles with rd=0 or wen=0, and commit_pc SHALL equal the latched pc; without it, these ports and their registers SHALL be absent with identical other behaviour.

Structure
REQ-025 State encoding and load-size constants (BYTE=0, HALF=1, WORD=2) SHALL reside in the shared ysyx_23060124 package.
REQ-026 Load extraction SHALL be a combinational sub-module ysyx_23060124_load_ext.

Verification
REQ-027 ALU add, rd=5, result 0x1234_5678 accepted at cycle 10 -> rf_wen=1, rf_waddr=5, rf_wdata=0x1234_5678 at cycle 11; wbu_rd=5 at cycle 11.
REQ-028 lb, rd=3, addr low bits 2'b11, sign=1, mem_rvalid after 4 cycles with rdata 0x80FF_0000 -> rf_wdata=0xFFFF_FF80; in_ready=0 throughout LOAD_WAIT.
REQ-029 lhu, addr[1]=1, rdata 0xBEEF_0000 -> rf_wdata=0x0000_BEEF.
REQ-030 Three back-to-back ALU instructions with in_valid held high -> three consecutive rf_wen pulses and no bubble.
REQ-031 ALU instruction with rd=0 -> rf_wen stays 0 and wbu_rd=0; with the macro, commit_valid=1 for one cycle.
REQ-032 reset asserted in LOAD_WAIT, then mem_rvalid pulse -> no rf_wen, state IDLE, in_ready=1.
